// File: rtl/biquad_pkg.sv
// Shared types and constants for the biquad filter core and its variants.
package biquad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam int NTAPS = 5;

  localparam logic [2:0] TAP_B10 = 3'd0;
  localparam logic [2:0] TAP_B11 = 3'd1;
  localparam logic [2:0] TAP_B12 = 3'd2;
  localparam logic [2:0] TAP_A11 = 3'd3;
  localparam logic [2:0] TAP_A12 = 3'd4;

  localparam int ACC_GUARD = 3;

  localparam int COEF_REG_BITS = 16;

  // Coefficients live in the low half of each 32-bit bus register.
  function automatic logic [COEF_REG_BITS-1:0] coef_slice(input logic [31:0] reg_val);
    return reg_val[COEF_REG_BITS-1:0];
  endfunction

endpackage

// File: rtl/biquad_sat.sv
// Arithmetic right shift followed by saturation into a narrower signed range.
module biquad_sat #(
  parameter int IN_WIDTH  = 31,
  parameter int OUT_WIDTH = 12,
  parameter int SHIFT     = 15
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  logic signed [IN_WIDTH-1:0] shifted;

  assign shifted = din >>> SHIFT;

  // Fits when every bit above the output sign bit matches it.
  always_comb begin
    if ((&shifted[IN_WIDTH-1:OUT_WIDTH-1]) || (~|shifted[IN_WIDTH-1:OUT_WIDTH-1])) begin
      dout = shifted[OUT_WIDTH-1:0];
    end else if (shifted[IN_WIDTH-1]) begin
      dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/biquad_mac.sv
// Direct-form-I biquad evaluated with one shared multiplier over five MAC cycles.
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int DATAWIDTH = 12,
  parameter int COEFWIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [31:0]                 a11_i,
  input  logic [31:0]                 a12_i,
  input  logic [31:0]                 b10_i,
  input  logic [31:0]                 b11_i,
  input  logic [31:0]                 b12_i,
  input  logic signed [DATAWIDTH-1:0] x_i,
  input  logic                        x_valid_i,
  output logic                        x_ready_o,
  input  logic                        hist_clr_i,
  output logic signed [DATAWIDTH-1:0] y_o,
  output logic                        y_valid_o,
  output logic signed [DATAWIDTH-1:0] x_last_o,
  output logic                        overrun_o
);

  localparam int PW = DATAWIDTH + COEFWIDTH;
  localparam int AW = PW + ACC_GUARD;

  state_t                      state;
  logic [2:0]                  tap;
  logic signed [AW-1:0]        acc;
  logic signed [COEFWIDTH-1:0] b10_q, b11_q, b12_q, a11_q, a12_q;
  logic signed [DATAWIDTH-1:0] x0, x1, x2, y1, y2;
  logic [COEF_REG_BITS-1:0]    b10_raw, b11_raw, b12_raw, a11_raw, a12_raw;
  logic signed [DATAWIDTH-1:0] mul_x;
  logic signed [COEFWIDTH-1:0] mul_c;
  logic signed [PW-1:0]        product;
  logic signed [DATAWIDTH-1:0] sat_y;
  logic                        unused_hi;

  assign b10_raw = coef_slice(b10_i);
  assign b11_raw = coef_slice(b11_i);
  assign b12_raw = coef_slice(b12_i);
  assign a11_raw = coef_slice(a11_i);
  assign a12_raw = coef_slice(a12_i);

  assign unused_hi = ^{a11_i[31:16], a12_i[31:16], b10_i[31:16], b11_i[31:16], b12_i[31:16]};

  always_comb begin
    mul_x = '0;
    mul_c = '0;
    case (tap)
      TAP_B10: begin mul_x = x0; mul_c = b10_q; end
      TAP_B11: begin mul_x = x1; mul_c = b11_q; end
      TAP_B12: begin mul_x = x2; mul_c = b12_q; end
      TAP_A11: begin mul_x = y1; mul_c = a11_q; end
      TAP_A12: begin mul_x = y2; mul_c = a12_q; end
      default: ;
    endcase
  end

  assign product = PW'(mul_x) * PW'(mul_c);

  biquad_sat #(
    .IN_WIDTH (AW),
    .OUT_WIDTH(DATAWIDTH),
    .SHIFT    (COEFWIDTH - 1)
  ) u_sat (
    .din (acc),
    .dout(sat_y)
  );

  // A history clear outranks everything except reset, including a coincident accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tap       <= '0;
      acc       <= '0;
      x_ready_o <= 1'b1;
      y_o       <= '0;
      y_valid_o <= 1'b0;
      x_last_o  <= '0;
      overrun_o <= 1'b0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      b10_q     <= '0;
      b11_q     <= '0;
      b12_q     <= '0;
      a11_q     <= '0;
      a12_q     <= '0;
    end else begin
      y_valid_o <= 1'b0;
      if (x_valid_i && !x_ready_o) begin
        overrun_o <= 1'b1;
      end
      if (hist_clr_i) begin
        state     <= IDLE;
        tap       <= '0;
        acc       <= '0;
        x_ready_o <= 1'b1;
        x1        <= '0;
        x2        <= '0;
        y1        <= '0;
        y2        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (x_valid_i) begin
              x0        <= x_i;
              x_last_o  <= x_i;
              b10_q     <= b10_raw[COEF_REG_BITS-1 -: COEFWIDTH];
              b11_q     <= b11_raw[COEF_REG_BITS-1 -: COEFWIDTH];
              b12_q     <= b12_raw[COEF_REG_BITS-1 -: COEFWIDTH];
              a11_q     <= a11_raw[COEF_REG_BITS-1 -: COEFWIDTH];
              a12_q     <= a12_raw[COEF_REG_BITS-1 -: COEFWIDTH];
              acc       <= '0;
              tap       <= '0;
              x_ready_o <= 1'b0;
              state     <= MAC;
            end
          end
          MAC: begin
            acc <= acc + AW'(product);
            if (tap == 3'(NTAPS - 1)) begin
              state <= OUT;
            end else begin
              tap <= tap + 3'd1;
            end
          end
          OUT: begin
            y_o       <= sat_y;
            y_valid_o <= 1'b1;
            x2        <= x1;
            x1        <= x0;
            y2        <= y1;
            y1        <= sat_y;
            tap       <= '0;
            x_ready_o <= 1'b1;
            state     <= IDLE;
          end
          default: begin
            state     <= IDLE;
            x_ready_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_biquad_mac.sv
// Directed-vector bench for biquad_mac with hand-computed expected outputs.
module tb_biquad_mac;

  localparam int DW = 12;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [31:0]          a11_i, a12_i, b10_i, b11_i, b12_i;
  logic signed [DW-1:0] x_i;
  logic                 x_valid_i;
  logic                 x_ready_o;
  logic                 hist_clr_i;
  logic signed [DW-1:0] y_o;
  logic                 y_valid_o;
  logic signed [DW-1:0] x_last_o;
  logic                 overrun_o;

  int checks = 0;
  int errors = 0;
  int y_got;
  int lat_got;
  int pulses;

  int delay_x[3]   = '{1000, 0, 0};
  int delay_y[3]   = '{0, 500, 0};
  int recur_y[4]   = '{1023, 511, 255, 127};
  int sat_pos_y[3] = '{2046, 2047, 2047};

  biquad_mac #(
    .DATAWIDTH(12),
    .COEFWIDTH(16)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .a11_i     (a11_i),
    .a12_i     (a12_i),
    .b10_i     (b10_i),
    .b11_i     (b11_i),
    .b12_i     (b12_i),
    .x_i       (x_i),
    .x_valid_i (x_valid_i),
    .x_ready_o (x_ready_o),
    .hist_clr_i(hist_clr_i),
    .y_o       (y_o),
    .y_valid_o (y_valid_o),
    .x_last_o  (x_last_o),
    .overrun_o (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic setCoefs(input logic [31:0] b10, input logic [31:0] b11, input logic [31:0] b12,
                          input logic [31:0] a11, input logic [31:0] a12);
    b10_i = b10;
    b11_i = b11;
    b12_i = b12;
    a11_i = a11;
    a12_i = a12;
  endtask

  task automatic clearHistory();
    hist_clr_i = 1'b1;
    @(negedge clk_i);
    hist_clr_i = 1'b0;
  endtask

  // Offers one sample and waits for its strobe; hold keeps x_valid_i up into the MAC phase.
  task automatic applyStimulus(input int x, input int hold, input bit zero_b10_mid,
                               output int y, output int lat);
    int waited = 0;
    while (!x_ready_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("ready_before_accept", int'(x_ready_o), 1);
    x_i       = DW'(x);
    x_valid_i = 1'b1;
    @(posedge clk_i);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk_i);
      if (lat >= hold) x_valid_i = 1'b0;
      if (zero_b10_mid && lat == 1) b10_i = 32'h0;
      if (y_valid_o) break;
      @(posedge clk_i);
      lat++;
    end
    x_valid_i = 1'b0;
    y = int'(y_o);
    checkOutput("latency", lat, 6);
  endtask

  initial begin
    rst_i      = 1'b1;
    x_i        = '0;
    x_valid_i  = 1'b0;
    hist_clr_i = 1'b0;
    setCoefs(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    checkOutput("reset_y", int'(y_o), 0);
    checkOutput("reset_x_last", int'(x_last_o), 0);
    checkOutput("reset_overrun", int'(overrun_o), 0);
    checkOutput("reset_ready", int'(x_ready_o), 1);
    checkOutput("reset_y_valid", int'(y_valid_o), 0);

    x_i        = 12'sd100;
    x_valid_i  = 1'b1;
    hist_clr_i = 1'b1;
    @(negedge clk_i);
    x_valid_i  = 1'b0;
    hist_clr_i = 1'b0;
    checkOutput("clr_vs_valid_ready", int'(x_ready_o), 1);
    checkOutput("clr_vs_valid_x_last", int'(x_last_o), 0);
    checkOutput("clr_vs_valid_overrun", int'(overrun_o), 0);

    setCoefs(32'h7FFF, 32'h0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1024, 0, 1'b0, y_got, lat_got);
    checkOutput("pass_pos", y_got, 1023);
    checkOutput("pass_x_last", int'(x_last_o), 1024);
    @(negedge clk_i);
    checkOutput("pass_strobe_width", int'(y_valid_o), 0);
    applyStimulus(-1024, 0, 1'b0, y_got, lat_got);
    checkOutput("pass_neg", y_got, -1024);

    setCoefs(32'h0, 32'h4000, 32'h0, 32'h0, 32'h0);
    clearHistory();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(delay_x[i], 0, 1'b0, y_got, lat_got);
      checkOutput($sformatf("delay_%0d", i), y_got, delay_y[i]);
    end

    setCoefs(32'h7FFF, 32'h0, 32'h0, 32'h4000, 32'h0);
    clearHistory();
    applyStimulus(1024, 0, 1'b1, y_got, lat_got);
    checkOutput("recur_0_snapshot", y_got, recur_y[0]);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 0, 1'b0, y_got, lat_got);
      checkOutput($sformatf("recur_%0d", i), y_got, recur_y[i]);
    end

    setCoefs(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h0, 32'h0);
    clearHistory();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2047, 0, 1'b0, y_got, lat_got);
      checkOutput($sformatf("sat_pos_%0d", i), y_got, sat_pos_y[i]);
    end
    clearHistory();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(-2048, 0, 1'b0, y_got, lat_got);
      checkOutput($sformatf("sat_neg_%0d", i), y_got, -2048);
    end

    setCoefs(32'h7FFF, 32'h0, 32'h0, 32'h0, 32'h0);
    clearHistory();
    checkOutput("overrun_before", int'(overrun_o), 0);
    applyStimulus(1024, 2, 1'b0, y_got, lat_got);
    checkOutput("overrun_output", y_got, 1023);
    checkOutput("overrun_set", int'(overrun_o), 1);
    applyStimulus(-1024, 0, 1'b0, y_got, lat_got);
    checkOutput("overrun_next_output", y_got, -1024);
    checkOutput("overrun_sticky", int'(overrun_o), 1);

    // Abort at tap 2; x1 holds -1024 beforehand, so a missed clear would give -512 afterwards.
    setCoefs(32'h0, 32'h4000, 32'h0, 32'h0, 32'h0);
    x_i       = 12'sd1000;
    x_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    x_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    hist_clr_i = 1'b1;
    @(negedge clk_i);
    hist_clr_i = 1'b0;
    checkOutput("abort_ready", int'(x_ready_o), 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (y_valid_o) pulses++;
      @(negedge clk_i);
    end
    checkOutput("abort_no_strobe", pulses, 0);
    checkOutput("abort_y_hold", int'(y_o), -1024);
    checkOutput("abort_x_last_hold", int'(x_last_o), 1000);
    applyStimulus(1024, 0, 1'b0, y_got, lat_got);
    checkOutput("abort_history_cleared", y_got, 0);

    x_i       = 12'sd700;
    x_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    x_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("midrst_y", int'(y_o), 0);
    checkOutput("midrst_x_last", int'(x_last_o), 0);
    checkOutput("midrst_overrun", int'(overrun_o), 0);
    checkOutput("midrst_ready", int'(x_ready_o), 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (y_valid_o) pulses++;
      @(negedge clk_i);
    end
    checkOutput("midrst_no_strobe", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
